glyph_row_renderer: RTL and testbench

//  Reader side of the 5x6 digit glyph ROMs. Each ROM takes a 3-bit row select and returns a
//  5-bit row code. Per scanline, this block computes the glyph row from the scanline offset

---
 rtl/glyph_row_renderer.sv | 153 +++++++++++++++
 tb/tb_glyph_row_renderer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_renderer.sv
// Reads one row of a 5x6 digit glyph from the ROM and streams it out MSB-first as
// magnified pixels, followed by blank gap columns.
module glyph_row_renderer #(
  parameter int SCALE_LOG2 = 2,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       start,
  input  logic [5:0] line_in_cell,
  output logic [2:0] row_sel,
  input  logic [4:0] code_in,
  output logic       pix_on,
  output logic       pix_valid,
  output logic       busy,
  output logic       done
);

  // A zero-width tick counter is not legal, so SCALE_LOG2=0 keeps one bit pinned at 0.
  localparam int             SW       = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SW-1:0]  SC_MAX   = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [2:0]     GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] sc, sc_nx;
  logic [2:0]    col, col_nx;
  logic [4:0]    shreg, shreg_nx;
  logic          blank, blank_nx;
  logic [2:0]    row_sel_nx;
  logic          pix_on_nx, pix_valid_nx, busy_nx, done_nx;

  logic [5:0]    row;
  logic          sc_wrap, shift_end, gap_end, render_end;

  assign row        = line_in_cell >> SCALE_LOG2;
  assign sc_wrap    = pix_en && (sc == SC_MAX);
  assign shift_end  = (state == S_SHIFT) && sc_wrap && (col == 3'd4);
  assign gap_end    = (state == S_GAP) && sc_wrap && (col == GAP_LAST);
  assign render_end = (shift_end && (GAP == 0)) || gap_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sc        <= '0;
      col       <= '0;
      shreg     <= '0;
      blank     <= 1'b0;
      row_sel   <= '0;
      pix_on    <= 1'b0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      sc        <= sc_nx;
      col       <= col_nx;
      shreg     <= shreg_nx;
      blank     <= blank_nx;
      row_sel   <= row_sel_nx;
      pix_on    <= pix_on_nx;
      pix_valid <= pix_valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_SHIFT;
      S_SHIFT: if (shift_end) state_nx = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // pix_on is loaded with what shreg[4] will be after the edge, so it tracks the MSB
  // without an extra cycle of latency.
  always_comb begin
    sc_nx        = sc;
    col_nx       = col;
    shreg_nx     = shreg;
    blank_nx     = blank;
    row_sel_nx   = row_sel;
    pix_on_nx    = pix_on;
    pix_valid_nx = pix_valid;
    busy_nx      = busy;
    done_nx      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_nx = 1'b1;
          sc_nx   = '0;
          col_nx  = '0;
          if (row <= 6'd5) begin
            row_sel_nx = row[2:0];
            blank_nx   = 1'b0;
          end else begin
            row_sel_nx = 3'b111;
            blank_nx   = 1'b1;
          end
        end
      end
      S_FETCH: begin
        shreg_nx     = blank ? 5'd0 : code_in;
        pix_on_nx    = blank ? 1'b0 : code_in[4];
        pix_valid_nx = 1'b1;
      end
      S_SHIFT: begin
        if (pix_en) begin
          sc_nx = sc_wrap ? '0 : sc + SW'(1);
          if (sc_wrap) begin
            shreg_nx  = {shreg[3:0], 1'b0};
            pix_on_nx = shreg[3];
            col_nx    = col + 3'd1;
            if (col == 3'd4) begin
              col_nx    = '0;
              pix_on_nx = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (pix_en) begin
          sc_nx = sc_wrap ? '0 : sc + SW'(1);
          if (sc_wrap) col_nx = col + 3'd1;
        end
      end
      default: ;
    endcase

    if (render_end) begin
      sc_nx        = '0;
      col_nx       = '0;
      shreg_nx     = '0;
      pix_on_nx    = 1'b0;
      pix_valid_nx = 1'b0;
      busy_nx      = 1'b0;
      done_nx      = 1'b1;
    end
  end

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Drives three renderer instances with different scale/gap settings from one shared
// stimulus and checks every cycle against a tick-count model of the pixel stream.
module tb_glyph_row_renderer;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic start = 1'b0;
  logic [5:0] line_in_cell = 6'd0;
  logic [4:0] rom_tbl [8];

  logic [NI-1:0][2:0] row_sel_w;
  logic [NI-1:0][4:0] code_w;
  logic [NI-1:0]      pix_on_w, pix_valid_w, busy_w, done_w;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  int         m_st [NI];
  int         m_t [NI];
  logic [4:0] m_code [NI];
  logic       m_blank [NI];
  logic [2:0] e_row [NI];
  logic       e_pix [NI];
  logic       e_val [NI];
  logic       e_busy [NI];
  logic       e_done [NI];

  logic [31:0] cap [NI];
  int          capn [NI];
  int          dn [NI];

  // instance 0: scale 4, gap 1; instance 1: scale 1, gap 1; instance 2: scale 2, gap 0
  function automatic int sl(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 1;
  endfunction
  function automatic int gp(input int k);
    return (k == 2) ? 0 : 1;
  endfunction
  function automatic int scl(input int k);
    return 1 << sl(k);
  endfunction
  function automatic int row_of(input int k, input logic [5:0] line);
    return int'(line) >> sl(k);
  endfunction
  function automatic logic pixel_at(input logic [4:0] code, input int k, input int t);
    if (t < 5 * scl(k)) return code[4 - t / scl(k)];
    return 1'b0;
  endfunction

  assign code_w[0] = rom_tbl[row_sel_w[0]];
  assign code_w[1] = rom_tbl[row_sel_w[1]];
  assign code_w[2] = rom_tbl[row_sel_w[2]];

  glyph_row_renderer #(.SCALE_LOG2(2), .GAP(1)) u_dut_s2g1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .start(start),
    .line_in_cell(line_in_cell), .row_sel(row_sel_w[0]), .code_in(code_w[0]),
    .pix_on(pix_on_w[0]), .pix_valid(pix_valid_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  glyph_row_renderer #(.SCALE_LOG2(0), .GAP(1)) u_dut_s0g1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .start(start),
    .line_in_cell(line_in_cell), .row_sel(row_sel_w[1]), .code_in(code_w[1]),
    .pix_on(pix_on_w[1]), .pix_valid(pix_valid_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  glyph_row_renderer #(.SCALE_LOG2(1), .GAP(0)) u_dut_s1g0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .start(start),
    .line_in_cell(line_in_cell), .row_sel(row_sel_w[2]), .code_in(code_w[2]),
    .pix_on(pix_on_w[2]), .pix_valid(pix_valid_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  always #5 clk = ~clk;

  // Model: a render is a count of pix_en ticks after the fetch; the pixel shown after
  // tick t is glyph column t/scale, or blank once past the five glyph columns.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_st[k]    <= 0;
        m_t[k]     <= 0;
        m_code[k]  <= 5'd0;
        m_blank[k] <= 1'b0;
        e_row[k]   <= 3'd0;
        e_pix[k]   <= 1'b0;
        e_val[k]   <= 1'b0;
        e_busy[k]  <= 1'b0;
        e_done[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        e_done[k] <= 1'b0;
        case (m_st[k])
          0: if (start) begin
            e_row[k]   <= (row_of(k, line_in_cell) <= 5) ? 3'(row_of(k, line_in_cell)) : 3'd7;
            m_blank[k] <= (row_of(k, line_in_cell) > 5);
            e_busy[k]  <= 1'b1;
            m_st[k]    <= 1;
          end
          1: begin
            m_code[k] <= m_blank[k] ? 5'd0 : rom_tbl[e_row[k]];
            e_pix[k]  <= m_blank[k] ? 1'b0 : rom_tbl[e_row[k]][4];
            e_val[k]  <= 1'b1;
            m_t[k]    <= 0;
            m_st[k]   <= 2;
          end
          default: if (pix_en) begin
            if (m_t[k] + 1 == (5 + gp(k)) * scl(k)) begin
              m_st[k]   <= 0;
              e_val[k]  <= 1'b0;
              e_pix[k]  <= 1'b0;
              e_busy[k] <= 1'b0;
              e_done[k] <= 1'b1;
            end else begin
              m_t[k]   <= m_t[k] + 1;
              e_pix[k] <= pixel_at(m_code[k], k, m_t[k] + 1);
            end
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input int k, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s inst%0d @%0t: got %0h, expected %0h", name, k, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        checkOutput("row_sel", k, 32'(row_sel_w[k]), 32'(e_row[k]));
        checkOutput("pix_on", k, 32'(pix_on_w[k]), 32'(e_pix[k]));
        checkOutput("pix_valid", k, 32'(pix_valid_w[k]), 32'(e_val[k]));
        checkOutput("busy", k, 32'(busy_w[k]), 32'(e_busy[k]));
        checkOutput("done", k, 32'(done_w[k]), 32'(e_done[k]));
      end
    end
  end

  // pe_mode: 0 = pix_en always high, 1 = toggling starting low, 2 = random
  task automatic applyStimulus(input logic [5:0] line, input int pe_mode, input bit second_start);
    int cyc;
    bit all_idle;
    for (int k = 0; k < NI; k++) begin
      cap[k] = 32'd0;
      capn[k] = 0;
      dn[k] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    line_in_cell = line;
    pix_en = (pe_mode == 1) ? 1'b0 : (pe_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    all_idle = 1'b0;
    while (!all_idle && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = second_start && (cyc == 4);
      case (pe_mode)
        1:       pix_en = ~pix_en;
        2:       pix_en = 1'($urandom_range(0, 1));
        default: pix_en = 1'b1;
      endcase
      for (int k = 0; k < NI; k++) begin
        if (pix_valid_w[k]) begin
          cap[k] = {cap[k][30:0], pix_on_w[k]};
          capn[k]++;
        end
        if (done_w[k]) dn[k]++;
      end
      all_idle = (busy_w == '0);
    end
    start = 1'b0;
    if (!all_idle) checkOutput("render_timeout", 0, 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom_tbl[i] = 5'(i * 7 + 3);
    @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      checkOutput("reset_busy", k, 32'(busy_w[k]), 32'd0);
      checkOutput("reset_row_sel", k, 32'(row_sel_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    rom_tbl[2] = 5'b10101;
    applyStimulus(6'd2, 0, 1'b0);
    checkOutput("t1_pixels", 1, cap[1], 32'b101010);
    checkOutput("t1_count", 1, 32'(capn[1]), 32'd6);
    checkOutput("t1_done", 1, 32'(dn[1]), 32'd1);
    checkOutput("t1_row_sel", 1, 32'(row_sel_w[1]), 32'd2);

    rom_tbl[1] = 5'b11001;
    rom_tbl[2] = 5'b01110;
    applyStimulus(6'd5, 0, 1'b0);
    checkOutput("t2_pixels", 0, cap[0], 32'h00FF00F0);
    checkOutput("t2_count", 0, 32'(capn[0]), 32'd24);
    checkOutput("t2_row_sel", 0, 32'(row_sel_w[0]), 32'd1);
    checkOutput("t5_pixels", 2, cap[2], 32'b0011111100);
    checkOutput("t5_count", 2, 32'(capn[2]), 32'd10);

    rom_tbl[6] = 5'b11111;
    rom_tbl[7] = 5'b11111;
    applyStimulus(6'd24, 0, 1'b0);
    checkOutput("t3_pixels", 0, cap[0], 32'd0);
    checkOutput("t3_count", 0, 32'(capn[0]), 32'd24);
    checkOutput("t3_row_sel", 0, 32'(row_sel_w[0]), 32'd7);

    rom_tbl[2] = 5'b10101;
    applyStimulus(6'd2, 1, 1'b1);
    checkOutput("t4_pixels", 1, cap[1], 32'b110011001100);
    checkOutput("t4_count", 1, 32'(capn[1]), 32'd12);
    for (int k = 0; k < NI; k++) checkOutput("t4_done_count", k, 32'(dn[k]), 32'd1);

    @(negedge clk);
    start = 1'b1;
    line_in_cell = 6'd2;
    pix_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checkOutput("t6_async_pix_on", k, 32'(pix_on_w[k]), 32'd0);
      checkOutput("t6_async_valid", k, 32'(pix_valid_w[k]), 32'd0);
      checkOutput("t6_async_busy", k, 32'(busy_w[k]), 32'd0);
      checkOutput("t6_async_row_sel", k, 32'(row_sel_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rom_tbl[1] = 5'b11001;
    applyStimulus(6'd5, 0, 1'b0);
    checkOutput("t6_fresh_pixels", 0, cap[0], 32'h00FF00F0);
    checkOutput("t6_fresh_done", 0, 32'(dn[0]), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      line_in_cell = 6'($urandom_range(0, 40));
      pix_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rom_tbl[$urandom_range(0, 7)] = 5'($urandom);
    end

    start = 1'b0;
    pix_en = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (busy_w != '0 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (busy_w != '0) checkOutput("drain_timeout", 0, 32'(busy_w), 32'd0);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
